// File: rtl/cpu_pc_ctrl_if.sv
// rtl/cpu_pc_ctrl_if.sv - control requests in, program counter and return-stack status out
interface cpu_pc_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             jmp;
    logic             call;
    logic             ret;
    logic [WIDTH-1:0] jmp_address;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] lr_address;
    logic             stack_empty;
    logic             stack_full;
    logic             stack_err;

    modport master (
        output en, jmp, call, ret, jmp_address,
        input  pc, lr_address, stack_empty, stack_full, stack_err
    );

    modport slave (
        input  en, jmp, call, ret, jmp_address,
        output pc, lr_address, stack_empty, stack_full, stack_err
    );
endinterface

// File: rtl/cpu_pc_ctrl.sv
// rtl/cpu_pc_ctrl.sv - program counter with return stack; CPU_PC_STACK_ERR_EN selects the error-trapping stack policy
module cpu_pc_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    cpu_pc_ctrl_if.slave   bus
);
    localparam int SPW  = $clog2(DEPTH + 1);
    localparam int IDXW = $clog2(DEPTH);

    logic [WIDTH-1:0] stack [DEPTH];
    logic [WIDTH-1:0] pc_q, pc_d, pc_inc, top_entry;
    logic [SPW-1:0]   sp_q, sp_d;
    logic [IDXW-1:0]  top_idx, wr_idx;
    logic             push, empty, full;
`ifdef CPU_PC_STACK_ERR_EN
    logic             err_q, err_d;
`endif

    assign pc_inc    = pc_q + WIDTH'(1);
    assign empty     = (sp_q == '0);
    assign full      = (sp_q == SPW'(DEPTH));
    assign top_idx   = IDXW'(sp_q - SPW'(1));
    assign wr_idx    = IDXW'(sp_q);
    assign top_entry = stack[top_idx];

    // Priority RET > CALL > JMP > increment; a stalled cycle changes nothing.
    always_comb begin
        pc_d = pc_q;
        sp_d = sp_q;
        push = 1'b0;
`ifdef CPU_PC_STACK_ERR_EN
        err_d = err_q;
`endif
        if (bus.en) begin
            if (bus.ret) begin
                if (!empty) begin
                    pc_d = top_entry;
                    sp_d = sp_q - SPW'(1);
                end else begin
`ifdef CPU_PC_STACK_ERR_EN
                    pc_d  = pc_inc;
                    err_d = 1'b1;
`else
                    pc_d  = '0;
`endif
                end
            end else if (bus.call) begin
                if (!full) begin
                    push = 1'b1;
                    sp_d = sp_q + SPW'(1);
                    pc_d = bus.jmp_address;
                end else begin
`ifdef CPU_PC_STACK_ERR_EN
                    pc_d  = pc_inc;
                    err_d = 1'b1;
`else
                    pc_d  = bus.jmp_address;
`endif
                end
            end else if (bus.jmp) begin
                pc_d = bus.jmp_address;
            end else begin
                pc_d = pc_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= '0;
            sp_q <= '0;
        end else begin
            pc_q <= pc_d;
            sp_q <= sp_d;
        end
    end

`ifdef CPU_PC_STACK_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end
    assign bus.stack_err = err_q;
`else
    assign bus.stack_err = 1'b0;
`endif

    // Entries above SP are never observed, so the array needs no reset.
    always_ff @(posedge clk) begin
        if (push && rst_n) stack[wr_idx] <= pc_inc;
    end

    assign bus.pc          = pc_q;
    assign bus.lr_address  = empty ? '0 : top_entry;
    assign bus.stack_empty = empty;
    assign bus.stack_full  = full;
endmodule

// File: tb/tb_cpu_pc_ctrl.sv
// tb/tb_cpu_pc_ctrl.sv - scoreboard bench for cpu_pc_ctrl with a queue-based reference model
module tb_cpu_pc_ctrl;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    typedef struct {
        logic [7:0] pc;
        logic [7:0] lr;
        logic       empty;
        logic       full;
        logic       err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cpu_pc_ctrl_if #(.WIDTH(WIDTH)) bus ();
    cpu_pc_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    exp_t       sb[$];
    logic [7:0] m_stk[$];
    logic [7:0] m_pc;
    logic       m_err;
    int         n_vec  = 0;
    int         n_miss = 0;

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model_view();
        exp_t e;
        e.pc    = m_pc;
        e.lr    = (m_stk.size() > 0) ? m_stk[m_stk.size()-1] : 8'h00;
        e.empty = (m_stk.size() == 0);
        e.full  = (m_stk.size() == DEPTH);
        e.err   = m_err;
        return e;
    endfunction

    task automatic model_step(input logic en, input logic j, input logic c, input logic r,
                              input logic [7:0] a);
        if (!en) return;
        if (r) begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
`ifdef CPU_PC_STACK_ERR_EN
            else begin m_pc = m_pc + 8'd1; m_err = 1'b1; end
`else
            else m_pc = 8'h00;
`endif
        end else if (c) begin
            if (m_stk.size() < DEPTH) begin
                m_stk.push_back(m_pc + 8'd1);
                m_pc = a;
            end
`ifdef CPU_PC_STACK_ERR_EN
            else begin m_pc = m_pc + 8'd1; m_err = 1'b1; end
`else
            else m_pc = a;
`endif
        end else if (j) begin
            m_pc = a;
        end else begin
            m_pc = m_pc + 8'd1;
        end
    endtask

    // Issue one cycle of requests; returns 2 time units after the edge.
    task automatic step(input logic en, input logic j, input logic c, input logic r,
                        input logic [7:0] a);
        bus.en = en; bus.jmp = j; bus.call = c; bus.ret = r; bus.jmp_address = a;
        model_step(en, j, c, r, a);
        sb.push_back(model_view());
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        bus.en = 1'b0; bus.jmp = 1'b0; bus.call = 1'b0; bus.ret = 1'b0; bus.jmp_address = '0;
        #1 rst_n = 1'b0;
        #1;
        cmp("rst_pc",    16'(bus.pc),          16'h0);
        cmp("rst_lr",    16'(bus.lr_address),  16'h0);
        cmp("rst_empty", 16'(bus.stack_empty), 16'h1);
        cmp("rst_full",  16'(bus.stack_full),  16'h0);
        cmp("rst_err",   16'(bus.stack_err),   16'h0);
        m_pc = 8'h00;
        m_err = 1'b0;
        m_stk.delete();
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                cmp("pc",    16'(bus.pc),          16'(e.pc));
                cmp("lr",    16'(bus.lr_address),  16'(e.lr));
                cmp("empty", 16'(bus.stack_empty), 16'(e.empty));
                cmp("full",  16'(bus.stack_full),  16'(e.full));
                cmp("err",   16'(bus.stack_err),   16'(e.err));
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic en, j, c, r;
        do_reset();

        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h99);
        cmp("first_edge_stalled_pc", 16'(bus.pc), 16'h00);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        cmp("count_to_5", 16'(bus.pc), 16'h05);

        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h10);
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h40);
        cmp("call_lr", 16'(bus.lr_address), 16'h11);
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        cmp("ret_pc", 16'(bus.pc), 16'h11);

        do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h40);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h50);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h60);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h70);
        cmp("full_lr", 16'(bus.lr_address), 16'h62);
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h80);
`ifdef CPU_PC_STACK_ERR_EN
        cmp("overflow_pc", 16'(bus.pc), 16'h71);
        cmp("overflow_err", 16'(bus.stack_err), 16'h1);
`else
        cmp("overflow_pc", 16'(bus.pc), 16'h80);
        cmp("overflow_err", 16'(bus.stack_err), 16'h0);
`endif
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);

        do_reset();
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h20);
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
`ifdef CPU_PC_STACK_ERR_EN
        cmp("underflow_pc", 16'(bus.pc), 16'h21);
`else
        cmp("underflow_pc", 16'(bus.pc), 16'h00);
`endif

        do_reset();
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h32);
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h90);
        step(1'b1, 1'b1, 1'b1, 1'b1, 8'h55);
        cmp("prio_pc", 16'(bus.pc), 16'h33);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h77);
        cmp("stall_pc", 16'(bus.pc), 16'h33);

        step(1'b1, 1'b1, 1'b0, 1'b0, 8'hFF);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        cmp("wrap_pc", 16'(bus.pc), 16'h00);
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'hFF);
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h10);
        cmp("push_wrap_lr", 16'(bus.lr_address), 16'h00);
        do_reset();

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            en = ($urandom_range(0, 3) != 0);
            j  = ($urandom_range(0, 3) == 0);
            c  = ($urandom_range(0, 3) == 0);
            r  = ($urandom_range(0, 4) == 0);
            step(en, j, c, r, 8'($urandom));
        end

        cmp("sb_drained", 16'(sb.size()), 16'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/cpu_pc_ctrl.md
CPU_PC_CTRL -- requirements
Module: cpu_pc_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: address/PC width in bits.
REQ-002 Parameter DEPTH, default 4: return-stack entries, 2..16.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST_N  input  1  reset, asynchronous, active-low.
REQ-005 EN  input  1  advance enable; 0 = hold all state (stall).
REQ-006 JMP  input  1  take jump to JMP_ADDRESS.
REQ-007 CALL  input  1  push return address, jump to JMP_ADDRESS.
REQ-008 RET  input  1  pop return address into PC.
REQ-009 JMP_ADDRESS  input  WIDTH  target from jump-address unit.
REQ-010 PC  output  WIDTH  current program counter, registered.
REQ-011 LR_ADDRESS  output  WIDTH  top-of-stack entry (0 when empty), feeds jump unit CALL-relative mode.
REQ-012 STACK_EMPTY  output  1  stack holds 0 entries.
REQ-013 STACK_FULL  output  1  stack holds DEPTH entries.
REQ-014 STACK_ERR  output  1  sticky overflow/underflow flag.

Function
REQ-015 The block SHALL hold PC, a DEPTH x WIDTH stack array and a stack pointer SP (0..DEPTH entries).
REQ-016 With EN=0, PC, SP, stack and STACK_ERR SHALL hold regardless of JMP/CALL/RET.
REQ-017 With EN=1, priority SHALL be RET > CALL > JMP > increment; lower-priority requests in the same cycle are ignored.
REQ-018 Increment: PC <= PC+1 modulo 2^WIDTH (0xFF -> 0x00 at WIDTH=8).
REQ-019 JMP: PC <= JMP_ADDRESS next edge; stack untouched.
REQ-020 CALL not full: stack[SP] <= PC+1 (modulo 2^WIDTH), SP <= SP+1, PC <= JMP_ADDRESS, same edge.
REQ-021 RET not empty: PC <= stack[SP-1], SP <= SP-1, same edge.
REQ-022 Latency: one cycle from request to new PC; LR_ADDRESS, STACK_EMPTY, STACK_FULL are combinational from SP/stack and update in the cycle after a push/pop.
REQ-023 Full/empty: STACK_EMPTY = (SP==0); STACK_FULL = (SP==DEPTH); never both.
REQ-024 CALL while full and RET while empty: behaviour per REQ-029/REQ-030.

Reset
REQ-025 RST_N low SHALL immediately (no clock) set PC=0, SP=0, STACK_ERR=0; outputs LR_ADDRESS=0, STACK_EMPTY=1, STACK_FULL=0.
REQ-026 Stack array contents need not reset; they are unobservable while SP=0.
REQ-027 Reset asserted mid-CALL/RET SHALL abort the operation; no partial push/pop survives.
REQ-028 First PC change after RST_N deassertion occurs on the first rising edge with EN=1.

Configuration
REQ-029 Macro CPU_PC_STACK_ERR_EN defined: CALL while full SHALL not push and not jump (PC increments) and set STACK_ERR; RET while empty SHALL increment PC and set STACK_ERR; STACK_ERR clears only on reset.
REQ-030 Macro undefined: CALL while full SHALL jump and discard the push (SP unchanged); RET while empty SHALL load PC=0; STACK_ERR tied to 0.

Verification
REQ-031 Reset then 5 cycles EN=1, no requests -> PC 0,1,2,3,4,5; STACK_EMPTY=1.
REQ-032 PC=0x10, CALL with JMP_ADDRESS=0x40 -> PC=0x40, LR_ADDRESS=0x11, SP=1; then RET -> PC=0x11, STACK_EMPTY=1.
REQ-033 DEPTH=4: four nested CALLs from PC 0x01,0x41,0x51,0x61 -> STACK_FULL=1, LR_ADDRESS=0x62; fifth CALL -> with macro PC=next+1, STACK_ERR=1; without macro PC=JMP_ADDRESS, STACK_ERR=0, SP=4.
REQ-034 RET on empty stack at PC=0x20 -> with macro PC=0x21, STACK_ERR=1; without macro PC=0x00.
REQ-035 JMP+CALL+RET same cycle with one entry 0x33 -> PC=0x33, SP=0; EN=0 with CALL asserted -> no change.
REQ-036 PC=0xFF increment -> 0x00; CALL at PC=0xFF -> pushed 0x00; RST_N low mid-cycle after CALL -> PC=0, STACK_EMPTY=1 before next edge.
